// File: rtl/ps2_key_serializer.sv
// Turns hps_io ps2_key toggle events into Set-2 make/break bytes and sends them
// as device-side PS/2 frames, backing off whenever the host pulls its clock low.
`timescale 1ns/1ps
module ps2_key_serializer #(
    parameter logic [15:0] CLK_DIV = 16'd1250,
    parameter logic [15:0] GAP     = 16'd2500,
    parameter int          FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    input  logic             host_clk,
    output logic             ps2_clk_out,
    output logic             ps2_data_out,
    output logic             busy,
    output logic             overflow,
    output logic [FIFO_AW:0] fifo_level
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {EV_IDLE, EV_E0, EV_F0, EV_CODE} ev_state_t;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} ser_state_t;

    // Host clock synchroniser; resets to "released" so nothing looks inhibited.
    logic host_s1, host_s2, inh;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_s1 <= 1'b1;
            host_s2 <= 1'b1;
        end else begin
            host_s1 <= host_clk;
            host_s2 <= host_s1;
        end
    end
    assign inh = !host_s2;

    // FIFO write/pop contract: wr_en is only raised after the sequencer has
    // reserved room for the whole event, and pop only while a byte is queued,
    // so neither side needs a ready flag. Both may fire in the same cycle.
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               wr_en, pop, empty;
    logic [7:0]         wr_data, head;
    logic [FIFO_AW:0]   free;

    assign head  = mem[rd_ptr];
    assign empty = (fifo_level == '0);
    assign free  = DEPTH_L - fifo_level;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Event detection and enqueue sequencer.
    ev_state_t  ev_state, ev_next;
    logic       armed, prev_tgl, ev;
    logic       pend_valid, lat_rel, take, fits, direct, consume;
    logic [9:0] pend_key, sel_key;
    logic [7:0] lat_code;
    logic [1:0] need;

    assign ev      = armed && (ps2_key[10] != prev_tgl);
    assign direct  = (ev_state == EV_IDLE) && !pend_valid;
    assign consume = (ev_state == EV_IDLE) && pend_valid;
    assign sel_key = pend_valid ? pend_key : ps2_key[9:0];
    // Byte count = extended + released + 1, encoded without an adder.
    assign need    = {sel_key[8] | !sel_key[9], !(sel_key[8] ^ !sel_key[9])};
    assign fits    = free >= {{(FIFO_AW-1){1'b0}}, need};

    always_comb begin
        ev_next = ev_state;
        take    = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        case (ev_state)
            EV_IDLE: begin
                if (pend_valid || ev) begin
                    take = 1'b1;
                    if (fits) ev_next = sel_key[8] ? EV_E0 : (!sel_key[9] ? EV_F0 : EV_CODE);
                end
            end
            EV_E0: begin
                wr_en   = 1'b1;
                wr_data = 8'hE0;
                ev_next = lat_rel ? EV_F0 : EV_CODE;
            end
            EV_F0: begin
                wr_en   = 1'b1;
                wr_data = 8'hF0;
                ev_next = EV_CODE;
            end
            EV_CODE: begin
                wr_en   = 1'b1;
                wr_data = lat_code;
                ev_next = EV_IDLE;
            end
            default: ev_next = EV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_state   <= EV_IDLE;
            armed      <= 1'b0;
            prev_tgl   <= 1'b0;
            pend_valid <= 1'b0;
            pend_key   <= '0;
            lat_rel    <= 1'b0;
            lat_code   <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            ev_state <= ev_next;
            if (!armed) begin
                armed    <= 1'b1;
                prev_tgl <= ps2_key[10];
            end else if (ev) begin
                prev_tgl <= ps2_key[10];
            end
            if (take) begin
                if (fits) begin
                    lat_rel  <= !sel_key[9];
                    lat_code <= sel_key[7:0];
                end else begin
                    overflow <= 1'b1;
                end
            end
            // A new event not taken directly parks in the pending slot, which
            // frees up in the same cycle its old contents are consumed.
            if (ev && !direct) begin
                if (pend_valid && !consume) begin
                    overflow <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_key   <= ps2_key[9:0];
                end
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Frame serializer.
    ser_state_t  s_state, s_next;
    logic [15:0] cnt;
    logic [10:0] frame;
    logic [3:0]  bit_idx;
    logic        load, bit_inc, last, abortable;

    assign last      = (cnt == CLK_DIV - 16'd1);
    // The stop bit is past the point of no return: the byte counts as sent.
    assign abortable = inh && (bit_idx != 4'd10);

    always_comb begin
        s_next  = s_state;
        load    = 1'b0;
        bit_inc = 1'b0;
        pop     = 1'b0;
        case (s_state)
            S_IDLE: begin
                if (!empty && !inh) begin
                    load   = 1'b1;
                    s_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abortable)  s_next = S_IDLE;
                else if (last)  s_next = S_HIGH;
            end
            S_HIGH: begin
                if (abortable)  s_next = S_IDLE;
                else if (last)  s_next = S_LOW;
            end
            S_LOW: begin
                if (abortable) begin
                    s_next = S_IDLE;
                end else if (last) begin
                    if (bit_idx == 4'd10) begin
                        pop    = 1'b1;
                        s_next = S_GAP;
                    end else begin
                        bit_inc = 1'b1;
                        s_next  = S_SETUP;
                    end
                end
            end
            S_GAP: begin
                if (cnt == GAP - 16'd1) s_next = S_IDLE;
            end
            default: s_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_state <= S_IDLE;
            cnt     <= 16'd0;
            frame   <= 11'h7FF;
            bit_idx <= 4'd0;
        end else begin
            s_state <= s_next;
            cnt     <= (s_next != s_state) ? 16'd0 : cnt + 16'd1;
            if (load) begin
                frame   <= {1'b1, ~^head, head, 1'b0};
                bit_idx <= 4'd0;
            end else if (bit_inc) begin
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

    assign ps2_clk_out  = (s_state != S_LOW);
    assign ps2_data_out = (s_state == S_SETUP || s_state == S_HIGH || s_state == S_LOW)
                          ? frame[bit_idx] : 1'b1;
    assign busy         = !empty || (s_state != S_IDLE);

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench for ps2_key_serializer: frame contents, timing, inhibit retry,
// overflow, back-to-back events and asynchronous reset.
`timescale 1ns/1ps
module tb_ps2_key_serializer;
    localparam logic [15:0] CLK_DIV = 16'd4;
    localparam logic [15:0] GAP     = 16'd8;
    localparam int          FIFO_AW = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [10:0]      ps2_key = 11'd0;
    logic             host_clk = 1'b1;
    logic             ps2_clk_out, ps2_data_out, busy, overflow;
    logic [FIFO_AW:0] fifo_level;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    ps2_key_serializer #(.CLK_DIV(CLK_DIV), .GAP(GAP), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .host_clk(host_clk),
        .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out), .busy(busy),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frames as {stop, parity, d[7:0], start}, bit 0 sent first.
    localparam logic [10:0] FR_1C = 11'b1_0_00011100_0;
    localparam logic [10:0] FR_E0 = 11'b1_0_11100000_0;
    localparam logic [10:0] FR_F0 = 11'b1_1_11110000_0;
    localparam logic [10:0] FR_14 = 11'b1_1_00010100_0;
    localparam logic [10:0] FR_00 = 11'b1_1_00000000_0;
    localparam logic [10:0] FR_FF = 11'b1_1_11111111_0;

    task automatic send_event(input logic pressed, input logic ext, input logic [7:0] code);
        @(negedge clk);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    // Collects 11 clock-low pulses; ok drops on a short/long pulse, data moving
    // while the clock is low, or a timeout.
    task automatic recv_frame(output logic [10:0] bits, output logic ok,
                              output int first_fall, output int last_rise);
        int   n;
        int   w;
        logic prev;
        n = 0; w = 0; prev = 1'b1; ok = 1'b1; bits = '0; first_fall = 0; last_rise = 0;
        for (int t = 0; t < 800 && n < 11; t++) begin
            @(negedge clk);
            if (!ps2_clk_out) begin
                if (prev) begin
                    bits[n] = ps2_data_out;
                    w = 0;
                    if (n == 0) first_fall = cyc;
                end else if (ps2_data_out !== bits[n]) begin
                    ok = 1'b0;
                end
                w++;
            end else if (!prev) begin
                if (w != int'(CLK_DIV)) ok = 1'b0;
                last_rise = cyc;
                n++;
            end
            prev = ps2_clk_out;
        end
        if (n != 11) ok = 1'b0;
    endtask

    task automatic wait_falls(input int k, output logic ok);
        int   n;
        logic prev;
        n = 0; prev = ps2_clk_out; ok = 1'b0;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            if (prev && !ps2_clk_out) n++;
            prev = ps2_clk_out;
            if (n == k) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic low_seen;
        repeat (3) @(negedge clk);
        n_total++; if (ps2_clk_out !== 1'b1) $display("FAIL rst_clk got %b want 1", ps2_clk_out); else n_pass++;
        n_total++; if (ps2_data_out !== 1'b1) $display("FAIL rst_data got %b want 1", ps2_data_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL rst_level got %0d want 0", fifo_level); else n_pass++;
        reset = 1'b0;
        low_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!ps2_clk_out || busy) low_seen = 1'b1;
        end
        n_total++; if (low_seen !== 1'b0) $display("FAIL rst_quiet got activity=%b want 0", low_seen); else n_pass++;
    endtask

    task automatic test_press_a;
        logic [10:0] bits;
        logic        ok;
        int          ff, lr;
        send_event(1'b1, 1'b0, 8'h1C);
        recv_frame(bits, ok, ff, lr);
        n_total++; if (bits !== FR_1C) $display("FAIL press_a_bits got %b want %b", bits, FR_1C); else n_pass++;
        n_total++; if (ok !== 1'b1) $display("FAIL press_a_timing got %b want 1", ok); else n_pass++;
        wait_idle(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL press_a_idle got %b want 1", ok); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL press_a_level got %0d want 0", fifo_level); else n_pass++;
    endtask

    task automatic test_release_ext;
        logic [10:0] exp_fr [3];
        logic [10:0] bits;
        logic        ok;
        int          ff, lr, prev_lr;
        logic [FIFO_AW:0] peak;
        exp_fr = '{FR_E0, FR_F0, FR_14};
        peak = '0;
        prev_lr = 0;
        send_event(1'b0, 1'b1, 8'h14);
        repeat (5) begin
            @(negedge clk);
            if (fifo_level > peak) peak = fifo_level;
        end
        n_total++; if (peak !== 3'd3) $display("FAIL rel_peak got %0d want 3", peak); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            recv_frame(bits, ok, ff, lr);
            n_total++; if (bits !== exp_fr[i]) $display("FAIL rel_bits%0d got %b want %b", i, bits, exp_fr[i]); else n_pass++;
            n_total++; if (ok !== 1'b1) $display("FAIL rel_timing%0d got %b want 1", i, ok); else n_pass++;
            // Gap, one IDLE decision cycle, then SETUP and HIGH of the next start bit.
            if (i > 0) begin
                n_total++;
                if (ff - prev_lr != int'(GAP) + 1 + 2 * int'(CLK_DIV))
                    $display("FAIL rel_gap%0d got %0d want %0d", i, ff - prev_lr, int'(GAP) + 1 + 2 * int'(CLK_DIV));
                else n_pass++;
            end
            prev_lr = lr;
        end
        wait_idle(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rel_idle got %b want 1", ok); else n_pass++;
    endtask

    task automatic test_inhibit;
        logic [10:0] bits;
        logic        ok;
        int          ff, lr;
        send_event(1'b1, 1'b0, 8'h1C);
        wait_falls(6, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL inh_reach_bit5 got %b want 1", ok); else n_pass++;
        host_clk = 1'b0;
        repeat (30) @(negedge clk);
        n_total++; if (ps2_clk_out !== 1'b1) $display("FAIL inh_clk got %b want 1", ps2_clk_out); else n_pass++;
        n_total++; if (ps2_data_out !== 1'b1) $display("FAIL inh_data got %b want 1", ps2_data_out); else n_pass++;
        n_total++; if (fifo_level !== 3'd1) $display("FAIL inh_level got %0d want 1", fifo_level); else n_pass++;
        host_clk = 1'b1;
        recv_frame(bits, ok, ff, lr);
        n_total++; if (bits !== FR_1C) $display("FAIL inh_resend got %b want %b", bits, FR_1C); else n_pass++;
        n_total++; if (ok !== 1'b1) $display("FAIL inh_timing got %b want 1", ok); else n_pass++;
        wait_idle(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL inh_idle got %b want 1", ok); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL inh_level_end got %0d want 0", fifo_level); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits;
        logic        ok;
        int          ff, lr;
        @(negedge clk);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h00};
        @(negedge clk);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'hFF};
        recv_frame(bits, ok, ff, lr);
        n_total++; if (bits !== FR_00) $display("FAIL b2b_first got %b want %b", bits, FR_00); else n_pass++;
        recv_frame(bits, ok, ff, lr);
        n_total++; if (bits !== FR_FF) $display("FAIL b2b_second got %b want %b", bits, FR_FF); else n_pass++;
        n_total++; if (ok !== 1'b1) $display("FAIL b2b_timing got %b want 1", ok); else n_pass++;
        wait_idle(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL b2b_idle got %b want 1", ok); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL b2b_ovf got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_overflow;
        host_clk = 1'b0;
        repeat (4) @(negedge clk);
        send_event(1'b0, 1'b1, 8'h14);
        repeat (6) @(negedge clk);
        n_total++; if (fifo_level !== 3'd3) $display("FAIL ovf_first_level got %0d want 3", fifo_level); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_first_flag got %b want 0", overflow); else n_pass++;
        send_event(1'b0, 1'b1, 8'h14);
        repeat (6) @(negedge clk);
        n_total++; if (fifo_level !== 3'd3) $display("FAIL ovf_second_level got %0d want 3", fifo_level); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_second_flag got %b want 1", overflow); else n_pass++;
        send_event(1'b0, 1'b1, 8'h14);
        repeat (6) @(negedge clk);
        n_total++; if (fifo_level !== 3'd3) $display("FAIL ovf_third_level got %0d want 3", fifo_level); else n_pass++;
        // One free slot still takes a one-byte make code, filling the FIFO.
        send_event(1'b1, 1'b0, 8'h1C);
        repeat (6) @(negedge clk);
        n_total++; if (fifo_level !== 3'd4) $display("FAIL ovf_fill_level got %0d want 4", fifo_level); else n_pass++;
        n_total++; if (ps2_clk_out !== 1'b1) $display("FAIL ovf_inhibited_clk got %b want 1", ps2_clk_out); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic ok;
        logic spurious;
        if (ps2_key[10] !== 1'b1) send_event(1'b1, 1'b0, 8'h1C);
        host_clk = 1'b1;
        wait_falls(3, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rmf_reach got %b want 1", ok); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (ps2_clk_out !== 1'b1) $display("FAIL rmf_clk got %b want 1", ps2_clk_out); else n_pass++;
        n_total++; if (ps2_data_out !== 1'b1) $display("FAIL rmf_data got %b want 1", ps2_data_out); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL rmf_level got %0d want 0", fifo_level); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL rmf_ovf got %b want 0", overflow); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        spurious = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!ps2_clk_out || busy) spurious = 1'b1;
        end
        n_total++; if (spurious !== 1'b0) $display("FAIL rmf_spurious got %b want 0", spurious); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_press_a();
        test_release_ext();
        test_inhibit();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
